stopwatch_ctrl: RTL and testbench

//  Button-level sequencer for the stopwatch counter. Debounces two raw push buttons (start/stop, lap/clear) and issues
//  one-cycle set/clear command pulses to the counter. Tracks run/pause/lap state and drives a registered display bus

---
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the stopwatch counter: debounces start/stop and lap/clear,
// issues one-cycle set/clear pulses and drives a live or lap-frozen display bus.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int LAP_MAX         = 15
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  input  logic [6:0] sw_m_seconds,
  output logic       set,
  output logic       clear,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic [6:0] disp_m_seconds,
  output logic       running,
  output logic       lap_active,
  output logic       saturated,
  output logic [3:0] lap_count,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LAP   = 3'd2,
    S_PAUSE = 3'd3,
    S_SAT   = 3'd4
  } state_t;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LAP_SAT = 4'(LAP_MAX);

  // Index 0 is start/stop, index 1 is lap/clear.
  logic [1:0] w_raw;
  logic [3:0] r_db_cnt [2];
  logic [1:0] r_flt;
  logic [1:0] r_flt_q;
  logic [1:0] w_ev;
  logic       w_ev_start;
  logic       w_ev_lap;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_set_nxt;
  logic        w_clear_nxt;
  logic        w_latch;
  logic [3:0]  w_cnt_nxt;
  logic        w_sw_max;
  logic [18:0] w_sw;

  assign w_raw      = {btn_lap, btn_start};
  assign w_ev       = r_flt & ~r_flt_q;
  assign w_ev_start = w_ev[0];
  assign w_ev_lap   = w_ev[1] & ~w_ev[0];
  assign w_sw       = {sw_minutes, sw_seconds, sw_m_seconds};
  assign w_sw_max   = (sw_minutes == 6'd59) && (sw_seconds == 6'd59) && (sw_m_seconds == 7'd99);
  assign o_dbg_state = r_state;

  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_flt   <= 2'b00;
      r_flt_q <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= 4'd0;
    end else begin
      r_flt_q <= r_flt;
      for (int i = 0; i < 2; i++) begin
        if (w_raw[i] == r_flt[i]) begin
          r_db_cnt[i] <= 4'd0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_flt[i]    <= ~r_flt[i];
          r_db_cnt[i] <= 4'd0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Saturation outranks any same-cycle button event while the counter runs.
  always_comb begin
    w_state_nxt = r_state;
    w_set_nxt   = 1'b0;
    w_clear_nxt = 1'b0;
    w_latch     = 1'b0;
    w_cnt_nxt   = lap_count;
    case (r_state)
      S_IDLE: begin
        if (w_ev_start) begin
          w_set_nxt   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN, S_LAP: begin
        if (w_sw_max) begin
          w_state_nxt = S_SAT;
        end else if (w_ev_start) begin
          w_set_nxt   = 1'b1;
          w_state_nxt = S_PAUSE;
        end else if (w_ev_lap) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LAP;
          if (lap_count != LAP_SAT) w_cnt_nxt = lap_count + 4'd1;
        end
      end
      S_PAUSE: begin
        if (w_ev_start) begin
          w_set_nxt   = 1'b1;
          w_state_nxt = S_RUN;
        end else if (w_ev_lap) begin
          w_clear_nxt = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end
      end
      S_SAT: begin
        if (w_ev_lap) begin
          w_clear_nxt = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      set            <= 1'b0;
      clear          <= 1'b0;
      lap_count      <= 4'd0;
      running        <= 1'b0;
      lap_active     <= 1'b0;
      saturated      <= 1'b0;
      disp_minutes   <= 6'd0;
      disp_seconds   <= 6'd0;
      disp_m_seconds <= 7'd0;
    end else begin
      r_state    <= w_state_nxt;
      set        <= w_set_nxt;
      clear      <= w_clear_nxt;
      lap_count  <= w_cnt_nxt;
      running    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      lap_active <= (w_state_nxt == S_LAP);
      saturated  <= (w_state_nxt == S_SAT);
      if ((w_state_nxt != S_LAP) || w_latch)
        {disp_minutes, disp_seconds, disp_m_seconds} <= w_sw;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations, then random
// buttons/counter values, all checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int D       = 2;
  localparam int LAP_MAX = 15;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_SAT   = 4;

  logic       m_clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic [5:0] sw_min = '0;
  logic [5:0] sw_sec = '0;
  logic [6:0] sw_ms = '0;
  logic       set, clear, running, lap_active, saturated;
  logic [5:0] disp_min, disp_sec;
  logic [6:0] disp_ms;
  logic [3:0] lap_count;
  logic [2:0] dbg_state;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .LAP_MAX(LAP_MAX)) dut (
    .m_clk(m_clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .sw_minutes(sw_min), .sw_seconds(sw_sec), .sw_m_seconds(sw_ms),
    .set(set), .clear(clear),
    .disp_minutes(disp_min), .disp_seconds(disp_sec), .disp_m_seconds(disp_ms),
    .running(running), .lap_active(lap_active), .saturated(saturated),
    .lap_count(lap_count), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 m_clk = ~m_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: debounced level flips once the last D raw samples all differ from it
  int  m_mode;
  bit  m_valid = 1'b0;
  int  e_set, e_clear, e_cnt, e_min, e_sec, e_ms;
  int  f_min, f_sec, f_ms;
  bit  hist_s[$];
  bit  hist_l[$];
  bit  lvl_s, lvl_l, ev_s, ev_l, new_lvl, max_now, do_s, do_l;

  function automatic bit flips(input bit h[$], input bit lvl);
    if (h.size() < D) return 1'b0;
    for (int k = 0; k < D; k++)
      if (h[h.size() - 1 - k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge m_clk) begin
    if (reset) begin
      m_mode = M_IDLE; e_set = 0; e_clear = 0; e_cnt = 0;
      f_min = 0; f_sec = 0; f_ms = 0;
      e_min = 0; e_sec = 0; e_ms = 0;
      hist_s.delete(); hist_l.delete();
      lvl_s = 0; lvl_l = 0; ev_s = 0; ev_l = 0;
    end else begin
      max_now = (sw_min == 6'd59) && (sw_sec == 6'd59) && (sw_ms == 7'd99);
      do_s = ev_s;
      do_l = ev_l && !ev_s;
      e_set = 0;
      e_clear = 0;
      case (m_mode)
        M_IDLE: if (do_s) begin e_set = 1; m_mode = M_RUN; end
        M_RUN, M_LAP: begin
          if (max_now) m_mode = M_SAT;
          else if (do_s) begin e_set = 1; m_mode = M_PAUSE; end
          else if (do_l) begin
            f_min = int'(sw_min); f_sec = int'(sw_sec); f_ms = int'(sw_ms);
            if (e_cnt < LAP_MAX) e_cnt++;
            m_mode = M_LAP;
          end
        end
        M_PAUSE: begin
          if (do_s) begin e_set = 1; m_mode = M_RUN; end
          else if (do_l) begin e_clear = 1; e_cnt = 0; m_mode = M_IDLE; end
        end
        default: if (do_l) begin e_clear = 1; e_cnt = 0; m_mode = M_IDLE; end
      endcase
      if (m_mode == M_LAP) begin
        e_min = f_min; e_sec = f_sec; e_ms = f_ms;
      end else begin
        e_min = int'(sw_min); e_sec = int'(sw_sec); e_ms = int'(sw_ms);
      end
      hist_s.push_back(btn_start);
      if (hist_s.size() > D) void'(hist_s.pop_front());
      hist_l.push_back(btn_lap);
      if (hist_l.size() > D) void'(hist_l.pop_front());
      new_lvl = flips(hist_s, lvl_s) ? !lvl_s : lvl_s;
      ev_s = new_lvl && !lvl_s;
      lvl_s = new_lvl;
      new_lvl = flips(hist_l, lvl_l) ? !lvl_l : lvl_l;
      ev_l = new_lvl && !lvl_l;
      lvl_l = new_lvl;
    end
    m_valid = 1'b1;
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge m_clk) begin
    if (m_valid) begin
      check("set", int'(set), e_set);
      check("clear", int'(clear), e_clear);
      check("running", int'(running), int'(m_mode == M_RUN || m_mode == M_LAP));
      check("lap_active", int'(lap_active), int'(m_mode == M_LAP));
      check("saturated", int'(saturated), int'(m_mode == M_SAT));
      check("lap_count", int'(lap_count), e_cnt);
      check("disp_min", int'(disp_min), e_min);
      check("disp_sec", int'(disp_sec), e_sec);
      check("disp_ms", int'(disp_ms), e_ms);
    end
  end

  // driver tasks
  int n_set_seen = 0;
  int n_clr_seen = 0;

  task automatic tick();
    @(negedge m_clk);
    n_set_seen += int'(set);
    n_clr_seen += int'(clear);
  endtask

  task automatic press(input bit s, input bit l, input int hold);
    btn_start = s;
    btn_lap   = l;
    repeat (hold) tick();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (D + 3) tick();
  endtask

  task automatic set_sw(input int cs);
    sw_min = 6'(cs / 6000);
    sw_sec = 6'((cs / 100) % 60);
    sw_ms  = 7'(cs % 100);
  endtask

  int first_set;
  int cs;

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    check("rst_set", int'(set), 0);
    check("rst_running", int'(running), 0);
    check("rst_lap_count", int'(lap_count), 0);
    check("rst_disp", int'({disp_min, disp_sec, disp_ms}), 0);
    reset = 1'b0;

    // one-cycle glitch must not pass the filter
    n_set_seen = 0;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    repeat (6) tick();
    check("glitch_sets", n_set_seen, 0);
    check("glitch_running", int'(running), 0);

    // press latency and single pulse
    n_set_seen = 0;
    first_set = -1;
    btn_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (set && first_set < 0) first_set = c;
      if (c == 5) btn_start = 1'b0;
    end
    repeat (3) tick();
    check("press_latency", first_set, D + 1);
    check("press_sets", n_set_seen, 1);
    check("press_running", int'(running), 1);

    // lap split freezes the display while the counter moves on
    sw_min = 6'd0; sw_sec = 6'd12; sw_ms = 7'd34;
    btn_lap = 1'b1;
    repeat (4) tick();
    sw_sec = 6'd50; sw_ms = 7'd7;
    btn_lap = 1'b0;
    repeat (5) tick();
    check("lap_disp_min", int'(disp_min), 0);
    check("lap_disp_sec", int'(disp_sec), 12);
    check("lap_disp_ms", int'(disp_ms), 34);
    check("lap_count1", int'(lap_count), 1);
    check("lap_active1", int'(lap_active), 1);
    n_set_seen = 0;
    press(1'b1, 1'b0, 3);
    check("lap_stop_sets", n_set_seen, 1);
    check("pause_lap_active", int'(lap_active), 0);
    check("pause_live_sec", int'(disp_sec), 50);
    check("pause_live_ms", int'(disp_ms), 7);

    // clear from pause
    n_set_seen = 0; n_clr_seen = 0;
    press(1'b0, 1'b1, 3);
    check("pclr_clears", n_clr_seen, 1);
    check("pclr_sets", n_set_seen, 0);
    check("pclr_lap_count", int'(lap_count), 0);
    check("pclr_running", int'(running), 0);

    // saturation
    press(1'b1, 1'b0, 3);
    set_sw(359999);
    n_set_seen = 0;
    tick();
    check("sat_flag", int'(saturated), 1);
    press(1'b1, 1'b0, 3);
    check("sat_start_ignored", n_set_seen, 0);
    check("sat_still", int'(saturated), 1);
    n_clr_seen = 0;
    press(1'b0, 1'b1, 3);
    check("sat_clears", n_clr_seen, 1);
    check("sat_exit", int'(saturated), 0);
    check("sat_exit_running", int'(running), 0);
    set_sw(0);

    // simultaneous events from idle: start wins
    n_set_seen = 0; n_clr_seen = 0;
    press(1'b1, 1'b1, 3);
    check("both_sets", n_set_seen, 1);
    check("both_clears", n_clr_seen, 0);
    check("both_running", int'(running), 1);
    check("both_lap_active", int'(lap_active), 0);

    // reset while in lap
    set_sw(4321);
    press(1'b0, 1'b1, 3);
    check("lap2_active", int'(lap_active), 1);
    reset = 1'b1;
    tick();
    check("lrst_outputs", int'({set, clear, running, lap_active, saturated, lap_count}), 0);
    check("lrst_disp", int'({disp_min, disp_sec, disp_ms}), 0);
    reset = 1'b0;

    // randomized phase, model-checked every cycle
    cs = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 6) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(0, 1) == 1 && cs < 359999) cs++;
      if ($urandom_range(0, 299) == 0) cs = 359999 - int'($urandom_range(0, 20));
      if ($urandom_range(0, 399) == 0) cs = 0;
      set_sw(cs);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    btn_start = 1'b0;
    btn_lap = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
